bram1_requester: RTL and testbench

//  Initiator for the single-ported BRAM: turns a valid/ready request stream into
//  EN/WE/ADDR/DI strobes, tracks read latency (1 or 2 cycles per PIPELINED) and

---
 rtl/bram1_requester_if.sv | 39 +++
 rtl/bram1_requester.sv | 192 +++++++++++++++++++
 tb/tb_bram1_requester.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram1_requester_if.sv
// Request, response and BRAM strobe bundle for bram1_requester.
// rsp_err exists only when BRAM1_REQ_ERR_EN is defined.
interface bram1_requester_if #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
`ifdef BRAM1_REQ_ERR_EN
    logic                  rsp_err;
`endif
    logic                  bram_en;
    logic                  bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_di;
    logic [DATA_WIDTH-1:0] bram_do;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, bram_do,
        output req_ready, rsp_valid, rsp_rdata, bram_en, bram_we, bram_addr, bram_di
`ifdef BRAM1_REQ_ERR_EN
        , output rsp_err
`endif
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, bram_do,
        input  req_ready, rsp_valid, rsp_rdata, bram_en, bram_we, bram_addr, bram_di
`ifdef BRAM1_REQ_ERR_EN
        , input rsp_err
`endif
    );
endinterface

// File: rtl/bram1_requester.sv
// Single-port BRAM initiator: issues request strobes, tracks read latency and returns
// read data through a credit-guarded FIFO. Optional range check: BRAM1_REQ_ERR_EN.
module bram1_requester #(
    parameter int PIPELINED  = 0,
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int MEMSIZE    = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bram1_requester_if.master bus
);
    localparam int LAT = 1 + PIPELINED;
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int OW  = $clog2(RSP_DEPTH + LAT + 1);

    function automatic logic [OW-1:0] popcount(input logic [LAT-1:0] v);
        logic [OW-1:0] n;
        n = '0;
        for (int i = 0; i < LAT; i++) begin
            n = n + OW'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(RSP_DEPTH - 1)) begin
            r = '0;
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    logic [LAT-1:0]        inflight_q, inflight_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];

    logic [OW-1:0]         outstanding_s;
    logic                  credit_ok_s;
    logic                  req_ready_s;
    logic                  accept_s;
    logic                  rd_accept_s;
    logic                  in_range_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  push_err_s;
    logic [DATA_WIDTH-1:0] push_data_s;

`ifdef BRAM1_REQ_ERR_EN
    logic [LAT-1:0]        err_inflight_q, err_inflight_d;
    logic                  err_mem_q [RSP_DEPTH];
`endif

    // Acceptance: writes always pass, reads need a free slot counting in-flight and queued data
    always_comb begin
        outstanding_s = popcount(inflight_q) + OW'(count_q);
        credit_ok_s   = (outstanding_s < OW'(RSP_DEPTH));
        if (rst_i) begin
            req_ready_s = 1'b0;
        end else if (bus.req_write) begin
            req_ready_s = 1'b1;
        end else begin
            req_ready_s = credit_ok_s;
        end
        accept_s    = bus.req_valid & req_ready_s;
        rd_accept_s = accept_s & ~bus.req_write;
`ifdef BRAM1_REQ_ERR_EN
        in_range_s  = (32'(bus.req_addr) < 32'(MEMSIZE));
`else
        in_range_s  = 1'b1;
`endif
    end

    assign bus.req_ready = req_ready_s;
    assign bus.bram_en   = accept_s & in_range_s;
    assign bus.bram_we   = bus.req_write;
    assign bus.bram_addr = bus.req_addr;
    assign bus.bram_di   = bus.req_wdata;

    assign push_s = inflight_q[LAT-1];
    assign pop_s  = rsp_valid_q & bus.rsp_ready;

`ifdef BRAM1_REQ_ERR_EN
    assign push_err_s     = err_inflight_q[LAT-1];
    assign err_inflight_d = LAT'({err_inflight_q, rd_accept_s & ~in_range_s});
`else
    assign push_err_s     = 1'b0;
`endif
    assign push_data_s = push_err_s ? '0 : bus.bram_do;

    // Next state of latency tracker, occupancy and FIFO pointers
    always_comb begin
        inflight_d = LAT'({inflight_q, rd_accept_s});
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        rsp_valid_d = (count_d != '0);
    end

    // Control state; reset drops every in-flight read and queued response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
`ifdef BRAM1_REQ_ERR_EN
            err_inflight_q <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                err_mem_q[i] <= 1'b0;
            end
`endif
        end else begin
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef BRAM1_REQ_ERR_EN
            err_inflight_q <= err_inflight_d;
            if (push_s) begin
                err_mem_q[wr_ptr_q] <= push_err_s;
            end
`endif
        end
    end

    // Response data words; left unreset because the output is masked while empty
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_data_s;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_valid_q ? mem_q[rd_ptr_q] : '0;
`ifdef BRAM1_REQ_ERR_EN
    assign bus.rsp_err   = rsp_valid_q ? err_mem_q[rd_ptr_q] : 1'b0;
`endif

    bram1_requester_chk #(
        .LAT       (LAT),
        .RSP_DEPTH (RSP_DEPTH),
        .MEMSIZE   (MEMSIZE),
        .CW        (CW)
    ) u_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .count_i (count_q)
    );
endmodule

// Simulation checks for bram1_requester: parameter sanity and FIFO overflow.
module bram1_requester_chk #(
    parameter int LAT       = 1,
    parameter int RSP_DEPTH = 4,
    parameter int MEMSIZE   = 1,
    parameter int CW        = 3
) (
    input logic          clk_i,
    input logic          rst_i,
    input logic          push_i,
    input logic [CW-1:0] count_i
);
    // The FIFO must hold a full latency window of reads plus one
    a_params: assert property (@(posedge clk_i) (RSP_DEPTH >= LAT + 1) && (MEMSIZE >= 1));

    // Credit accounting must keep a push from ever landing on a full FIFO
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && (count_i == CW'(RSP_DEPTH))));
endmodule

// File: tb/tb_bram1_requester.sv
// Bench for bram1_requester: one latency-1 and one latency-2 instance share randomized
// stimulus and are checked every cycle against a transaction-level reference model.
module tb_bram1_requester;
    localparam int AW      = 4;
    localparam int DW      = 8;
    localparam int DEPTH   = 4;
    localparam int MEMSIZE = 8;
`ifdef BRAM1_REQ_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req_valid, req_write, rsp_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    int            pin_code;
    bit            done;

    bram1_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    bram1_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.req_valid = req_valid;
    assign bus0.req_write = req_write;
    assign bus0.req_addr  = req_addr;
    assign bus0.req_wdata = req_wdata;
    assign bus0.rsp_ready = rsp_ready;
    assign bus1.req_valid = req_valid;
    assign bus1.req_write = req_write;
    assign bus1.req_addr  = req_addr;
    assign bus1.req_wdata = req_wdata;
    assign bus1.rsp_ready = rsp_ready;

    bram1_requester #(.PIPELINED(0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEMSIZE(MEMSIZE),
                      .RSP_DEPTH(DEPTH)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
    bram1_requester #(.PIPELINED(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEMSIZE(MEMSIZE),
                      .RSP_DEPTH(DEPTH)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

    // Behavioural BRAMs: latency 1 for dut0, registered output (latency 2) for dut1
    logic [DW-1:0] bmem0 [16];
    logic [DW-1:0] bmem1 [16];
    logic [DW-1:0] d0, d1a, d1b;
    always @(posedge clk) begin
        if (bus0.bram_en) begin
            if (bus0.bram_we) bmem0[bus0.bram_addr] <= bus0.bram_di;
            else              d0 <= bmem0[bus0.bram_addr];
        end
    end
    always @(posedge clk) begin
        if (bus1.bram_en) begin
            if (bus1.bram_we) bmem1[bus1.bram_addr] <= bus1.bram_di;
            else              d1a <= bmem1[bus1.bram_addr];
        end
        d1b <= d1a;
    end
    assign bus0.bram_do = d0;
    assign bus1.bram_do = d1b;

    logic [1:0]    o_req_ready, o_rsp_valid, o_en, o_we;
    logic [AW-1:0] o_addr  [2];
    logic [DW-1:0] o_di    [2];
    logic [DW-1:0] o_rdata [2];
    assign o_req_ready = {bus1.req_ready, bus0.req_ready};
    assign o_rsp_valid = {bus1.rsp_valid, bus0.rsp_valid};
    assign o_en        = {bus1.bram_en,   bus0.bram_en};
    assign o_we        = {bus1.bram_we,   bus0.bram_we};
    assign o_addr[0]  = bus0.bram_addr;
    assign o_addr[1]  = bus1.bram_addr;
    assign o_di[0]    = bus0.bram_di;
    assign o_di[1]    = bus1.bram_di;
    assign o_rdata[0] = bus0.rsp_rdata;
    assign o_rdata[1] = bus1.rsp_rdata;
`ifdef BRAM1_REQ_ERR_EN
    logic [1:0] o_err;
    assign o_err = {bus1.rsp_err, bus0.rsp_err};
`endif

    // Reference model: per instance, a ring of expected responses (data, err, cycle when visible)
    logic [DW-1:0] shadow [2][16];
    logic [DW-1:0] qd [2][16];
    logic          qe [2][16];
    int            qv [2][16];
    int            qh [2];
    int            qt [2];
    int            n_cmp, n_bad, cyc_g;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, expected %0h (cycle %0d)", nm, inst, act, exp, cyc_g);
        end
    endtask

    task automatic check_inst(input int i);
        int  cnt, lat, hi;
        bit  exp_rdy, inr, exp_en, exp_rv;
        logic [DW-1:0] exp_rd;
        lat = (i == 0) ? 1 : 2;
        cnt = qt[i] - qh[i];
        hi  = qh[i] % 16;
        exp_rdy = !rst && (req_write || (cnt < DEPTH));
        inr     = !ERR || (int'(req_addr) < MEMSIZE);
        exp_en  = req_valid && exp_rdy && inr;
        exp_rv  = !rst && (cnt > 0) && (qv[i][hi] <= cyc_g);
        exp_rd  = exp_rv ? qd[i][hi] : '0;
        chk("req_ready", i, 32'(o_req_ready[i]), 32'(exp_rdy));
        chk("bram_en",   i, 32'(o_en[i]),        32'(exp_en));
        chk("rsp_valid", i, 32'(o_rsp_valid[i]), 32'(exp_rv));
        chk("rsp_rdata", i, 32'(o_rdata[i]),     32'(exp_rd));
        if (exp_en) begin
            chk("bram_we",   i, 32'(o_we[i]),   32'(req_write));
            chk("bram_addr", i, 32'(o_addr[i]), 32'(req_addr));
            chk("bram_di",   i, 32'(o_di[i]),   32'(req_wdata));
        end
`ifdef BRAM1_REQ_ERR_EN
        chk("rsp_err", i, 32'(o_err[i]), 32'(exp_rv ? qe[i][hi] : 1'b0));
`endif
        if (rst) begin
            qh[i] = 0;
            qt[i] = 0;
        end else begin
            if (exp_rv && rsp_ready) qh[i]++;
            if (req_valid && exp_rdy && !req_write) begin
                qd[i][qt[i] % 16] = inr ? shadow[i][req_addr] : '0;
                qe[i][qt[i] % 16] = !inr;
                qv[i][qt[i] % 16] = cyc_g + lat + 1;
                qt[i]++;
            end
            if (req_valid && req_write && inr) shadow[i][req_addr] = req_wdata;
        end
    endtask

    // Compare process: model check for both instances plus literal spot checks each cycle
    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc_g = 0;
        for (int i = 0; i < 2; i++) begin
            qh[i] = 0;
            qt[i] = 0;
            for (int a = 0; a < 16; a++) shadow[i][a] = '0;
        end
        while (!done && cyc_g < 20000) begin
            @(negedge clk);
            cyc_g++;
            case (pin_code)
                1: begin
                    chk("pin_rst_ready", 0, 32'(o_req_ready), 32'h0);
                    chk("pin_rst_valid", 0, 32'(o_rsp_valid), 32'h0);
                    chk("pin_rst_en",    0, 32'(o_en),        32'h0);
                    chk("pin_rst_rdata", 1, 32'(o_rdata[1]),  32'h0);
                end
                2: begin
                    chk("pin_w_en",   0, 32'(o_en[0]),   32'h1);
                    chk("pin_w_addr", 0, 32'(o_addr[0]), 32'h3);
                    chk("pin_w_di",   0, 32'(o_di[0]),   32'h5A);
                end
                3: chk("pin_no_bypass", 0, 32'(o_rsp_valid[0]), 32'h0);
                4: begin
                    chk("pin_l1_valid", 0, 32'(o_rsp_valid[0]), 32'h1);
                    chk("pin_l1_data",  0, 32'(o_rdata[0]),     32'h5A);
                    chk("pin_l2_early", 1, 32'(o_rsp_valid[1]), 32'h0);
                end
                5: begin
                    chk("pin_l2_valid", 1, 32'(o_rsp_valid[1]), 32'h1);
                    chk("pin_l2_data",  1, 32'(o_rdata[1]),     32'h5A);
                end
                6: chk("pin_credit_4th", 0, 32'(o_req_ready), 32'h3);
                7: begin
                    chk("pin_credit_full", 0, 32'(o_req_ready), 32'h0);
                    chk("pin_credit_en",   0, 32'(o_en),        32'h0);
                end
                8: chk("pin_stream", 0, 32'(o_req_ready), 32'h3);
                9: begin
                    chk("pin_midrst_valid", 0, 32'(o_rsp_valid), 32'h0);
                    chk("pin_midrst_en",    0, 32'(o_en),        32'h0);
                end
                10: chk("pin_oor_write_en", 0, 32'(o_en), 32'h0);
                default: ;
            endcase
            check_inst(0);
            check_inst(1);
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL watchdog: got cycle %0d, expected stimulus to finish earlier", cyc_g);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus: directed scenarios followed by randomized traffic with reset pulses
    initial begin
        done = 1'b0;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        pin_code = 0;
        tick(); tick();
        pin_code = 1;
        tick();
        pin_code = 0;
        rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(a); req_wdata = DW'($urandom);
            tick();
        end
        req_addr = AW'(3); req_wdata = 8'h5A; rsp_ready = 1'b1; pin_code = 2;
        tick();
        req_write = 1'b0; pin_code = 0;
        tick();
        req_valid = 1'b0; pin_code = 3;
        tick();
        pin_code = 4;
        tick();
        pin_code = 5;
        tick();
        pin_code = 0;
        repeat (3) tick();
        rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0;
        for (int k = 0; k < 6; k++) begin
            req_addr = AW'(k + 4);
            pin_code = (k == 3) ? 6 : ((k >= 4) ? 7 : 0);
            tick();
        end
        pin_code = 0; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (10) tick();
        req_valid = 1'b1;
        for (int a = 0; a < 16; a++) begin
            req_addr = AW'(a);
            pin_code = (a >= 8) ? 8 : 0;
            tick();
        end
        pin_code = 0;
        rsp_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            req_addr = AW'($urandom_range(7));
            tick();
        end
        rst = 1'b1; pin_code = 9;
        tick();
        rst = 1'b0; pin_code = 0; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (8) tick();
        req_valid = 1'b1; req_addr = AW'(5);
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        if (ERR) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(9); req_wdata = 8'hC3; pin_code = 10;
            tick();
            pin_code = 0; req_write = 1'b0;
            tick();
            req_addr = AW'(7);
            tick();
            req_valid = 1'b0;
            repeat (6) tick();
        end
        for (int n = 0; n < 3000; n++) begin
            req_valid = ($urandom_range(3) != 0);
            req_write = ($urandom_range(2) == 0);
            req_addr  = AW'($urandom_range(15));
            req_wdata = DW'($urandom);
            rsp_ready = (n < 1500) ? ($urandom_range(1) == 1) : n[0];
            rst       = ($urandom_range(499) == 0);
            tick();
        end
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (20) tick();
        done = 1'b1;
    end
endmodule
